// File: rtl/plpbot_uart_tx_sched_if.sv
// Requester and UART-core signal bundle for the PLPBot transmit scheduler.
// master = requesters + UART core side, slave = scheduler side.
interface plpbot_uart_tx_sched_if #(
    parameter int FIFO_AW = 3
);
    logic [3:0]       req_valid;
    logic [31:0]      req_data;
    logic [3:0]       req_ready;
    logic             uart_cts;
    logic             uart_send;
    logic [7:0]       uart_data;
    logic [FIFO_AW:0] fifo_count;
    logic             busy;

    modport master (
        output req_valid, req_data, uart_cts,
        input  req_ready, uart_send, uart_data, fifo_count, busy
    );

    modport slave (
        input  req_valid, req_data, uart_cts,
        output req_ready, uart_send, uart_data, fifo_count, busy
    );
endinterface

// File: rtl/plpbot_uart_tx_sched.sv
// Round-robin byte scheduler feeding a FIFO that drives the PLPBot UART core
// send/cts handshake. All state moves on the falling clock edge, like the core.
module plpbot_uart_tx_sched #(
    parameter int FIFO_AW = 3
) (
    input logic                  clk,
    input logic                  rst,
    plpbot_uart_tx_sched_if.slave bus_if
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_LO, WAIT_HI} state_t;

    state_t               state_q, state_d;
    logic                 miss_q, miss_d;
    logic                 retry_q, retry_d;
    logic                 send_q;
    logic [7:0]           data_q;
    logic [1:0]           rr_q;
    logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]     count_q;
    logic [7:0]           mem [DEPTH];

    logic [7:0]           req_byte [4];
    logic [3:0]           grant;
    logic [1:0]           grant_idx;
    logic [1:0]           scan_idx;
    logic                 found;
    logic                 push, pop;

    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        assign req_byte[gi] = bus_if.req_data[8*gi +: 8];
    end

    // Scan from rr_q upward; the first valid requester wins while there is room.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        scan_idx  = '0;
        found     = 1'b0;
        if (!rst && (count_q < FULL_CNT)) begin
            for (int k = 0; k < 4; k++) begin
                scan_idx = rr_q + 2'(k);
                if (!found && bus_if.req_valid[scan_idx]) begin
                    found           = 1'b1;
                    grant[scan_idx] = 1'b1;
                    grant_idx       = scan_idx;
                end
            end
        end
    end

    assign push = found;
    assign pop  = (state_q == LOAD) && (count_q != '0);

    always_ff @(negedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= req_byte[grant_idx];
        end
    end

    always_comb begin
        state_d = state_q;
        miss_d  = miss_q;
        retry_d = retry_q;
        case (state_q)
            IDLE:    if ((count_q != '0) && bus_if.uart_cts) state_d = LOAD;
            LOAD: begin
                state_d = SEND;
                retry_d = 1'b0;
            end
            SEND: begin
                state_d = WAIT_LO;
                miss_d  = 1'b0;
            end
            // The core should drop cts on the send edge; allow two looks, then
            // resend once, then give up on the byte.
            WAIT_LO: begin
                if (!bus_if.uart_cts) begin
                    state_d = WAIT_HI;
                end else if (!miss_q) begin
                    miss_d = 1'b1;
                end else if (!retry_q) begin
                    state_d = SEND;
                    retry_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_HI: if (bus_if.uart_cts) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            miss_q   <= 1'b0;
            retry_q  <= 1'b0;
            send_q   <= 1'b0;
            data_q   <= 8'h00;
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            retry_q <= retry_d;
            send_q  <= (state_d == SEND);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                rr_q     <= grant_idx + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                data_q   <= mem[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus_if.req_ready  = grant;
    assign bus_if.uart_send  = send_q;
    assign bus_if.uart_data  = data_q;
    assign bus_if.fifo_count = count_q;
    assign bus_if.busy       = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_plpbot_uart_tx_sched.sv
// Directed bench for plpbot_uart_tx_sched with a simple cts model of the UART core.
module tb_plpbot_uart_tx_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cts_man = 1'b1;
    logic model_en = 1'b1;
    logic model_cts = 1'b1;
    logic model_s = 1'b0;
    int   low_cnt = 0;
    int   send_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;

    plpbot_uart_tx_sched_if #(.FIFO_AW(3)) dif ();

    plpbot_uart_tx_sched #(.FIFO_AW(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (dif.slave)
    );

    always #5 clk = ~clk;

    assign dif.uart_cts = model_en ? model_cts : cts_man;

    // UART core stand-in: cts drops after each send pulse and stays low 10 cycles.
    always @(negedge clk) begin
        model_s = dif.uart_send;
        #1;
        if (model_en && model_s) low_cnt = 10;
        else if (low_cnt != 0) low_cnt = low_cnt - 1;
        model_cts = (low_cnt == 0);
    end

    always @(negedge clk) begin
        if (dif.uart_send === 1'b1) send_cnt = send_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
    endtask

    task automatic wait_send(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (dif.uart_send === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit got);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (dif.busy === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit   got;
        int   base;
        int   n61;
        logic stable;
        logic [7:0] hold;

        dif.req_valid = 4'b1111;
        dif.req_data  = 32'h0;

        // Reset state, with all requesters asking
        @(posedge clk);
        chk("rst_ready", dif.req_ready, 4'b0000);
        chk("rst_send", dif.uart_send, 1'b0);
        chk("rst_data", dif.uart_data, 8'h00);
        chk("rst_count", dif.fifo_count, 4'd0);
        chk("rst_busy", dif.busy, 1'b0);
        @(posedge clk);
        rst = 1'b0;
        dif.req_valid = 4'b0000;

        // Test 1: single byte, latency and one send pulse
        base = send_cnt;
        @(posedge clk);
        dif.req_valid = 4'b0001;
        dif.req_data  = 32'h0000_0041;
        #1 chk("t1_ready", dif.req_ready, 4'b0001);
        @(posedge clk);
        chk("t1_count1", dif.fifo_count, 4'd1);
        dif.req_valid = 4'b0000;
        #1 chk("t1_ready_off", dif.req_ready, 4'b0000);
        @(posedge clk);
        chk("t1_load_nosend", dif.uart_send, 1'b0);
        chk("t1_load_busy", dif.busy, 1'b1);
        @(posedge clk);
        chk("t1_send", dif.uart_send, 1'b1);
        chk("t1_data", dif.uart_data, 8'h41);
        chk("t1_count0", dif.fifo_count, 4'd0);
        @(posedge clk);
        chk("t1_send_off", dif.uart_send, 1'b0);
        wait_idle(got);
        chk("t1_idle", got, 1'b1);
        chk("t1_pulses", send_cnt - base, 1);

        // Test 2: fill the FIFO with cts low, round-robin from requester 0
        @(posedge clk);
        rst = 1'b1;
        model_en = 1'b0;
        cts_man  = 1'b0;
        @(posedge clk);
        rst = 1'b0;
        base = send_cnt;
        @(posedge clk);
        dif.req_valid = 4'b1111;
        dif.req_data  = 32'h1312_1110;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("t2_count%0d", k), dif.fifo_count, k);
            chk($sformatf("t2_grant%0d", k), dif.req_ready, 4'b0001 << (k % 4));
            @(posedge clk);
        end
        #1;
        chk("t2_full", dif.fifo_count, 4'd8);
        chk("t2_ready_full", dif.req_ready, 4'b0000);
        chk("t2_busy", dif.busy, 1'b1);
        chk("t2_nosend", send_cnt - base, 0);
        dif.req_valid = 4'b0000;

        // Test 3: drain with framed cts; order, pulse count and data stability
        base = send_cnt;
        model_en = 1'b1;
        for (int f = 0; f < 8; f++) begin
            wait_send(got);
            chk($sformatf("t3_send%0d", f), got, 1'b1);
            chk($sformatf("t3_data%0d", f), dif.uart_data, 8'h10 + 8'(f % 4));
            hold   = dif.uart_data;
            stable = 1'b1;
            repeat (11) begin
                @(posedge clk);
                if (dif.uart_data !== hold) stable = 1'b0;
            end
            chk($sformatf("t3_stable%0d", f), stable, 1'b1);
        end
        repeat (20) @(posedge clk);
        chk("t3_pulses", send_cnt - base, 8);
        chk("t3_empty", dif.fifo_count, 4'd0);
        chk("t3_idle", dif.busy, 1'b0);

        // Test 4: push and pop on the same edge at count 3
        model_en = 1'b0;
        cts_man  = 1'b0;
        @(posedge clk);
        dif.req_valid = 4'b0001;
        dif.req_data  = 32'h0000_00A0;
        @(posedge clk);
        dif.req_data  = 32'h0000_00A1;
        @(posedge clk);
        dif.req_data  = 32'h0000_00A2;
        @(posedge clk);
        dif.req_valid = 4'b0000;
        chk("t4_count3", dif.fifo_count, 4'd3);
        cts_man = 1'b1;
        @(posedge clk);
        dif.req_valid = 4'b0100;
        dif.req_data  = 32'h00C2_0000;
        #1 chk("t4_ready2", dif.req_ready, 4'b0100);
        @(posedge clk);
        chk("t4_count_same", dif.fifo_count, 4'd3);
        chk("t4_data", dif.uart_data, 8'hA0);
        chk("t4_send", dif.uart_send, 1'b1);
        dif.req_valid = 4'b1111;
        #1 chk("t4_rr3", dif.req_ready, 4'b1000);
        dif.req_valid = 4'b0011;
        #1 chk("t4_rr_wrap", dif.req_ready, 4'b0001);
        dif.req_data  = 32'h0000_0055;
        model_en = 1'b1;

        // Test 5: async reset mid-frame in WAIT_HI with five bytes queued
        @(posedge clk);
        chk("t5_count4", dif.fifo_count, 4'd4);
        dif.req_data = 32'h0000_0056;
        @(posedge clk);
        dif.req_valid = 4'b0000;
        chk("t5_count5", dif.fifo_count, 4'd5);
        chk("t5_busy", dif.busy, 1'b1);
        chk("t5_data_hold", dif.uart_data, 8'hA0);
        @(posedge clk);
        dif.req_valid = 4'b1111;
        #2 rst = 1'b1;
        #1;
        chk("t5_send", dif.uart_send, 1'b0);
        chk("t5_count", dif.fifo_count, 4'd0);
        chk("t5_busy0", dif.busy, 1'b0);
        chk("t5_data", dif.uart_data, 8'h00);
        chk("t5_ready", dif.req_ready, 4'b0000);
        @(posedge clk);
        rst = 1'b0;
        dif.req_valid = 4'b0000;
        model_en = 1'b0;
        cts_man  = 1'b1;

        // Test 6: cts stuck high gives one retry, byte dropped, next byte loaded
        @(posedge clk);
        dif.req_valid = 4'b0001;
        dif.req_data  = 32'h0000_0061;
        @(posedge clk);
        dif.req_data  = 32'h0000_0062;
        @(posedge clk);
        dif.req_valid = 4'b0000;
        base = send_cnt;
        n61  = 0;
        got  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            if (dif.uart_send === 1'b1 && dif.uart_data === 8'h61) n61++;
            if (dif.uart_send === 1'b1 && dif.uart_data === 8'h62) begin
                got = 1'b1;
                break;
            end
        end
        chk("t6_next_loaded", got, 1'b1);
        chk("t6_pulses_61", n61, 2);
        chk("t6_pulses_before", send_cnt - base, 2);
        model_en = 1'b1;
        wait_idle(got);
        chk("t6_idle", got, 1'b1);
        chk("t6_pulses_total", send_cnt - base, 3);
        chk("t6_empty", dif.fifo_count, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/plpbot_uart_tx_sched.md
Name: plpbot_uart_tx_sched

Overview:
Transmit scheduler that shares the single PLPBot UART transmitter among four on-chip byte requesters (e.g. CPU mailbox, debug tracer, sensor streamer, PMC dump).
- Arbitrates requesters round-robin into a small byte FIFO.
- Sequences the UART core's send/cts handshake, holding the data byte stable for the whole frame.
- Sits between the requesters and the UART core's out_buffer/send/cts pins; no CPU polling of cts is needed.

Parameters:
FIFO_AW, 3, log2 of FIFO depth (depth = 8 entries of 8 bits)

Ports:
clk  in  1  system clock; all state updates on negedge clk, matching the UART core
rst  in  1  asynchronous active-high reset
req_valid  in  4  per-requester byte valid
req_data  in  32  packed bytes; requester i at [8i+7:8i]
req_ready  out  4  per-requester accept, one-hot or zero
uart_cts  in  1  UART core clear-to-send (1 = transmitter idle)
uart_send  out  1  one-cycle send pulse to UART core
uart_data  out  8  byte to UART core out_buffer, stable from LOAD until return to IDLE
fifo_count  out  FIFO_AW+1  current FIFO occupancy, 0..8
busy  out  1  high when FSM is not IDLE or fifo_count != 0

Behaviour:
- Reset (async, any time, including mid-frame) forces the following values:
  - FIFO pointers and count = 0
  - RR pointer = 0
  - FSM = IDLE
  - uart_send = 0
  - uart_data = 8'h00
  - busy = 0
  - req_ready = 0 while rst is high
- Arbitration (combinational from registered state):
  - If fifo_count < 8, grant the first i with req_valid[i] set, scanning rr_ptr, rr_ptr+1, ... modulo 4.
  - req_ready[i] = 1 only for the granted i; all zero when full or no valid.
  - A transfer occurs when req_valid[i] & req_ready[i]: push req_data byte i on the next negedge and set rr_ptr = i+1 mod 4.
  - rr_ptr is unchanged when there is no transfer.
- FIFO:
  - Circular, FIFO_AW-bit wrap-around pointers.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop only when count > 0 before the edge, so a byte pushed this cycle cannot be popped the same cycle.
  - Push is never attempted when full, because ready is low.
- Sequencer FSM (negedge clk):
  - IDLE: if fifo_count > 0 and uart_cts, go to LOAD.
  - LOAD: pop FIFO head into uart_data, go to SEND.
  - SEND: uart_send = 1 for exactly this cycle, go to WAIT_LO.
  - WAIT_LO: wait for uart_cts == 0 (the core drops cts on the send edge), go to WAIT_HI.
    - If cts is still 1 after 2 cycles in WAIT_LO, go back to SEND once (retry).
    - A second miss goes to IDLE, and the byte is dropped.
  - WAIT_HI: wait for uart_cts == 1 (frame complete), go to IDLE.
  - uart_send is registered and is 0 in every state except SEND.
- Latency:
  - Byte accepted at edge N on an empty FIFO with idle UART:
    - LOAD at N+1
    - uart_send high during the cycle after N+2
  - Back-to-back bytes have 3 cycles of overhead between frames (IDLE, LOAD, SEND).
- uart_data must not change in WAIT_LO or WAIT_HI, because the core samples it bit by bit during the frame.
- fifo_count reflects pushes and pops after each negedge.

Test Plan:
1. Reset, uart_cts=1, req_valid=4'b0001, req_data[7:0]=8'h41 for one cycle → req_ready=4'b0001, uart_data=8'h41, single one-cycle uart_send pulse 2 cycles later, fifo_count back to 0, busy low after cts rises.
2. All four valid continuously with bytes 8'h10, 8'h11, 8'h12, 8'h13, uart_cts held 0 → grants in order 0,1,2,3,0,1,2,3; fifo_count reaches 8, req_ready goes 4'b0000, no uart_send.
3. From the full state of test 2, the cts model emulates a 9600 8N1 frame (low 10 bit-times after each send) → bytes appear on uart_data in order 10,11,12,13,10,11,12,13; exactly 8 send pulses; uart_data stable during each frame.
4. Simultaneous push and pop at count=3 → count stays 3; rr_ptr advances past the granted requester.
5. Assert rst asynchronously between clock edges while in WAIT_HI with count=5 → uart_send=0, fifo_count=0, FSM IDLE, busy=0 immediately, without waiting for an edge.
6. uart_cts stuck at 1 after a send → exactly two uart_send pulses (original plus retry), FSM returns to IDLE, next FIFO byte is then loaded.
